// File: rtl/elastic_dpram_skid_if.sv
// One port of the elastic dual-port RAM: request stream (t_*) and response stream (i_*).
interface elastic_dpram_skid_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0]   t_addr;
    logic [DATA_W-1:0]   t_data;
    logic [DATA_W/8-1:0] t_be;
    logic                t_we;
    logic                t_valid;
    logic                t_ready;
    logic [ADDR_W-1:0]   i_addr;
    logic [DATA_W-1:0]   i_data;
    logic                i_valid;
    logic                i_ready;

    modport master (
        output t_addr, t_data, t_be, t_we, t_valid,
        input  t_ready,
        input  i_addr, i_data, i_valid,
        output i_ready
    );

    modport slave (
        input  t_addr, t_data, t_be, t_we, t_valid,
        output t_ready,
        output i_addr, i_data, i_valid,
        input  i_ready
    );
endinterface

// File: rtl/elastic_dpram_skid.sv
// Read-first dual-port RAM with per-port valid/ready streams and a 2-entry response skid.
// t_ready is derived only from registered credit state, never from i_ready.
module elastic_dpram_skid #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 11,
    parameter int WRITE_RESP = 1
) (
    input  logic                 clk,
    input  logic                 srst,
    elastic_dpram_skid_if.slave  p0,
    elastic_dpram_skid_if.slave  p1
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit WR_RESP = (WRITE_RESP != 0);

    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [BE_W-1:0]   req_be   [2];
    logic [1:0]        req_we;
    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;

    assign req_addr[0] = p0.t_addr;
    assign req_addr[1] = p1.t_addr;
    assign req_data[0] = p0.t_data;
    assign req_data[1] = p1.t_data;
    assign req_be[0]   = p0.t_be;
    assign req_be[1]   = p1.t_be;
    assign req_we      = {p1.t_we, p0.t_we};
    assign req_valid   = {p1.t_valid, p0.t_valid};
    assign rsp_ready   = {p1.i_ready, p0.i_ready};

    logic [DATA_W-1:0] mem [DEPTH];

    // pend_* holds the response of the request accepted on the previous edge
    logic [1:0]        pend_valid;
    logic [ADDR_W-1:0] pend_addr [2];
    logic [DATA_W-1:0] pend_data [2];
    logic [ADDR_W-1:0] skid_addr [2][2];
    logic [DATA_W-1:0] skid_data [2][2];
    logic [1:0]        stored    [2];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;

    logic [1:0]        t_ready;
    logic [1:0]        acc;
    logic [1:0]        out_valid;
    logic [ADDR_W-1:0] out_addr [2];
    logic [DATA_W-1:0] out_data [2];
    logic [1:0]        push;
    logic [1:0]        pop_skid;

    always_comb begin
        t_ready  = '0;
        acc      = '0;
        out_valid = '0;
        push     = '0;
        pop_skid = '0;
        for (int p = 0; p < 2; p++) begin
            out_addr[p] = pend_addr[p];
            out_data[p] = pend_data[p];
            t_ready[p]  = (stored[p] == 2'd0) || ((stored[p] == 2'd1) && !pend_valid[p]);
            acc[p]      = req_valid[p] && t_ready[p] && !srst;
            out_valid[p] = pend_valid[p] || (stored[p] != 2'd0);
            if (stored[p] != 2'd0) begin
                out_addr[p] = skid_addr[p][rd_ptr[p]];
                out_data[p] = skid_data[p][rd_ptr[p]];
            end
            // RAM output bypasses the skid only when nothing older is queued
            push[p]     = pend_valid[p] && !((stored[p] == 2'd0) && rsp_ready[p]);
            pop_skid[p] = out_valid[p] && rsp_ready[p] && (stored[p] != 2'd0);
        end
    end

    // Port 0 is written last so it wins on overlapping bytes
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (acc[1] && req_we[1] && req_be[1][b])
                mem[req_addr[1]][b*8 +: 8] <= req_data[1][b*8 +: 8];
            if (acc[0] && req_we[0] && req_be[0][b])
                mem[req_addr[0]][b*8 +: 8] <= req_data[0][b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pend_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int p = 0; p < 2; p++) begin
                pend_addr[p] <= '0;
                pend_data[p] <= '0;
                stored[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pend_valid[p] <= acc[p] && (!req_we[p] || WR_RESP);
                if (acc[p]) begin
                    pend_addr[p] <= req_addr[p];
                    pend_data[p] <= mem[req_addr[p]];
                end
                if (push[p])
                    wr_ptr[p] <= !wr_ptr[p];
                if (pop_skid[p])
                    rd_ptr[p] <= !rd_ptr[p];
                stored[p] <= stored[p] + {1'b0, push[p]} - {1'b0, pop_skid[p]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                skid_addr[p][wr_ptr[p]] <= pend_addr[p];
                skid_data[p][wr_ptr[p]] <= pend_data[p];
            end
        end
    end

    assign p0.t_ready = t_ready[0];
    assign p1.t_ready = t_ready[1];
    assign p0.i_valid = out_valid[0];
    assign p1.i_valid = out_valid[1];
    assign p0.i_addr  = out_addr[0];
    assign p1.i_addr  = out_addr[1];
    assign p0.i_data  = out_data[0];
    assign p1.i_data  = out_data[1];
endmodule
